// File: rtl/full_adder_if.sv
// Bundle of the adder's operand and result signals, for benches and datapaths
// that want to pass one adder connection around as a single handle.
interface full_adder_if #(
   parameter int WIDTH = 1
);
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             c_in;
   logic [WIDTH-1:0] sum;
   logic             c_out;
   logic [WIDTH-1:0] sum_q;
   logic             c_out_q;

   // The master drives the operands; the slave (the adder) returns the results.
   modport master (
      output a, b, c_in,
      input  sum, c_out, sum_q, c_out_q
   );

   modport slave (
      input  a, b, c_in,
      output sum, c_out, sum_q, c_out_q
   );
endinterface

// File: rtl/full_adder_bit.sv
// One-bit full-adder cell: sum is the three-input parity and c_out is the
// three-input majority.
module full_adder_bit (
   input  logic a,
   input  logic b,
   input  logic c_in,
   output logic sum,
   output logic c_out
);
   assign sum   = a ^ b ^ c_in;
   assign c_out = (a & b) | (a & c_in) | (b & c_in);
endmodule

// File: rtl/full_adder.sv
// Ripple-carry adder of WIDTH one-bit cells, with the combinational result
// also captured in a register for consumers that need a timing-closed copy.
module full_adder #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic [WIDTH-1:0] sum_q,
   output logic             c_out_q
);
   // c[i] is the carry into cell i; c[WIDTH] leaves the MSB cell.
   logic [WIDTH:0] c;

   assign c[0]  = c_in;
   assign c_out = c[WIDTH];

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
         full_adder_bit u_bit (
            .a     (a[gi]),
            .b     (b[gi]),
            .c_in  (c[gi]),
            .sum   (sum[gi]),
            .c_out (c[gi+1])
         );
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sum_q   <= '0;
         c_out_q <= 1'b0;
      end else begin
         sum_q   <= sum;
         c_out_q <= c_out;
      end
   end
endmodule

// File: tb/tb_full_adder.sv
// Directed and random checks of a 1-bit and an 8-bit full_adder sharing one
// clock and reset.
module tb_full_adder;
   logic clk    = 1'b0;
   logic clk_en = 1'b0;
   logic rst_n  = 1'b1;

   int checks   = 0;
   int failures = 0;

   full_adder_if #(.WIDTH(1)) bus1 ();
   full_adder_if #(.WIDTH(8)) bus8 ();

   full_adder #(.WIDTH(1)) dut1 (
      .clk     (clk),
      .rst_n   (rst_n),
      .a       (bus1.a),
      .b       (bus1.b),
      .c_in    (bus1.c_in),
      .sum     (bus1.sum),
      .c_out   (bus1.c_out),
      .sum_q   (bus1.sum_q),
      .c_out_q (bus1.c_out_q)
   );

   full_adder #(.WIDTH(8)) dut8 (
      .clk     (clk),
      .rst_n   (rst_n),
      .a       (bus8.a),
      .b       (bus8.b),
      .c_in    (bus8.c_in),
      .sum     (bus8.sum),
      .c_out   (bus8.c_out),
      .sum_q   (bus8.sum_q),
      .c_out_q (bus8.c_out_q)
   );

   // Clock stays parked low until clk_en is raised, so the first phase runs with no clock.
   always #5 if (clk_en) clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   logic [2:0] vin  [8];
   logic [1:0] vexp [8];
   logic [1:0] exp1;
   logic [8:0] exp9;
   logic [8:0] prev9;
   logic [7:0] ra, rb;
   logic       rc;

   initial begin
      vin[0] = 3'b000; vexp[0] = 2'b00;
      vin[1] = 3'b001; vexp[1] = 2'b01;
      vin[2] = 3'b011; vexp[2] = 2'b10;
      vin[3] = 3'b010; vexp[3] = 2'b01;
      vin[4] = 3'b111; vexp[4] = 2'b11;
      vin[5] = 3'b110; vexp[5] = 2'b10;
      vin[6] = 3'b101; vexp[6] = 2'b10;
      vin[7] = 3'b100; vexp[7] = 2'b01;

      bus8.a = 8'h00; bus8.b = 8'h00; bus8.c_in = 1'b0;

      // Combinational truth table with no clock running.
      for (int i = 0; i < 8; i++) begin
         {bus1.a, bus1.b, bus1.c_in} = vin[i];
         #1;
         check($sformatf("noclk_vec%0d", i), 64'({bus1.c_out, bus1.sum}), 64'(vexp[i]));
         #9;
      end

      // Reset held two cycles with all inputs high.
      rst_n = 1'b0;
      bus1.a = 1'b1; bus1.b = 1'b1; bus1.c_in = 1'b1;
      clk_en = 1'b1;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      check("rst_sum_q",    64'(bus1.sum_q),   64'd0);
      check("rst_c_out_q",  64'(bus1.c_out_q), 64'd0);
      check("rst_sum",      64'(bus1.sum),     64'd1);
      check("rst_c_out",    64'(bus1.c_out),   64'd1);
      check("rst_sum_q8",   64'(bus8.sum_q),   64'd0);
      check("rst_c_out_q8", 64'(bus8.c_out_q), 64'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("rel_sum_q",   64'(bus1.sum_q),   64'd1);
      check("rel_c_out_q", 64'(bus1.c_out_q), 64'd1);

      // Exhaustive 1-bit with the register path: registered equals prior cycle's result.
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         {bus1.a, bus1.b, bus1.c_in} = 3'(i);
         exp1 = 2'(bus1.a) + 2'(bus1.b) + 2'(bus1.c_in);
         #1;
         check($sformatf("w1_comb%0d", i), 64'({bus1.c_out, bus1.sum}), 64'(exp1));
         @(posedge clk);
         #1;
         check($sformatf("w1_reg%0d", i), 64'({bus1.c_out_q, bus1.sum_q}), 64'(exp1));
      end

      // 8-bit wrap-around corners.
      @(negedge clk);
      bus8.a = 8'hFF; bus8.b = 8'h00; bus8.c_in = 1'b1;
      #1;
      check("w8_ff_00_1", 64'({bus8.c_out, bus8.sum}), 64'h100);
      @(posedge clk);
      #1;
      check("w8_ff_00_1_q", 64'({bus8.c_out_q, bus8.sum_q}), 64'h100);
      @(negedge clk);
      bus8.a = 8'hFF; bus8.b = 8'hFF; bus8.c_in = 1'b1;
      #1;
      check("w8_ff_ff_1", 64'({bus8.c_out, bus8.sum}), 64'h1FF);
      @(posedge clk);
      #1;
      check("w8_ff_ff_1_q", 64'({bus8.c_out_q, bus8.sum_q}), 64'h1FF);

      // Random 8-bit vectors with a single-cycle reset pulse in the middle.
      prev9 = 9'h1FF;
      for (int k = 0; k < 1000; k++) begin
         @(negedge clk);
         ra = 8'($urandom);
         rb = 8'($urandom);
         rc = 1'($urandom);
         bus8.a = ra; bus8.b = rb; bus8.c_in = rc;
         rst_n = (k != 500);
         exp9 = {1'b0, ra} + {1'b0, rb} + 9'(rc);
         #1;
         check($sformatf("rnd_comb%0d", k), 64'({bus8.c_out, bus8.sum}), 64'(exp9));
         @(posedge clk);
         #1;
         if (k == 500)
            check($sformatf("rnd_rst%0d", k), 64'({bus8.c_out_q, bus8.sum_q}), 64'd0);
         else
            check($sformatf("rnd_reg%0d", k), 64'({bus8.c_out_q, bus8.sum_q}), 64'(exp9));
         prev9 = exp9;
      end
      rst_n = 1'b1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
